// File: rtl/bcd_display_pkg.sv
// Glyph constants and BCD-to-7-segment decode shared by the display blocks.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package bcd_display_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a set bit means the segment is lit.
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h00;
    localparam seg7_t SEG_DASH  = 7'h40;

    localparam seg7_t SEG_DIGIT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Active-high glyph for one nibble; A-F show a dash so a bad value stays visible.
    function automatic seg7_t bcd_to_seg7(input logic [3:0] nibble);
        seg7_t glyph;
        case (nibble)
            4'd0:    glyph = SEG_DIGIT[0];
            4'd1:    glyph = SEG_DIGIT[1];
            4'd2:    glyph = SEG_DIGIT[2];
            4'd3:    glyph = SEG_DIGIT[3];
            4'd4:    glyph = SEG_DIGIT[4];
            4'd5:    glyph = SEG_DIGIT[5];
            4'd6:    glyph = SEG_DIGIT[6];
            4'd7:    glyph = SEG_DIGIT[7];
            4'd8:    glyph = SEG_DIGIT[8];
            4'd9:    glyph = SEG_DIGIT[9];
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment glyph.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module bcd_seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    // Thin wrapper so the scan block can instantiate the shared decode.
    always_comb begin
        seg = bcd_to_seg7(nibble);
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Multiplexed 7-segment driver: captures BCD words, applies them only at frame wraps, scans digits.
// Latency: outputs registered from (idx, shown), 1 cycle; a new word shows from the next frame.
// Backpressure: none; every updated strobe is accepted, the last one before a wrap wins.
module bcd_seg7_scan
    import bcd_display_pkg::*;
#(
    parameter int DIGITS           = 3,
    parameter int CLOCKS_PER_DIGIT = 3,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit AN_ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING    = 1'b1,
    localparam int BCD_WIDTH       = DIGITS * 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BCD_WIDTH-1:0] bcd,
    input  logic                 updated,
    output logic [6:0]           seg,
    output logic [DIGITS-1:0]    an,
    output logic                 frame_start
);

    localparam int PW = (CLOCKS_PER_DIGIT > 1) ? $clog2(CLOCKS_PER_DIGIT) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(CLOCKS_PER_DIGIT - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    // XOR masks that turn active-high values into pin polarity; also the all-off levels.
    localparam seg7_t             SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{AN_ACTIVE_LOW}};

    logic [PW-1:0]        presc;
    logic [IW-1:0]        idx;
    logic [BCD_WIDTH-1:0] pend;
    logic                 pend_vld;
    logic [BCD_WIDTH-1:0] shown;

    logic                 presc_tc;
    logic                 wrap;
    logic [3:0]           cur_nibble;
    seg7_t                dec_seg;
    logic [DIGITS-1:0]    upper_nz;
    logic                 blank;
    seg7_t                seg_next;
    logic [DIGITS-1:0]    an_next;
    logic                 frame_first;

    assign presc_tc    = (presc == PRESC_LAST);
    assign wrap        = presc_tc && (idx == IDX_LAST);
    assign frame_first = (presc == '0) && (idx == '0);
    assign cur_nibble  = shown[{idx, 2'b00} +: 4];

    bcd_seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Prescaler and digit index: each digit holds for CLOCKS_PER_DIGIT cycles, idx wraps after the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc_tc) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Capture into pend mid-frame; swap shown only at the wrap so a frame never mixes two words.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_vld <= 1'b0;
            shown    <= '0;
        end else if (wrap) begin
            pend_vld <= 1'b0;
            if (updated) begin
                shown <= bcd;
            end else if (pend_vld) begin
                shown <= pend;
            end
        end else if (updated) begin
            pend     <= bcd;
            pend_vld <= 1'b1;
        end
    end

    // Leading-zero detection: upper_nz[k] is set when digit k or any higher digit is nonzero.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        upper_nz = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc         = acc | (|shown[k*4 +: 4]);
            upper_nz[k] = acc;
        end
        blank    = BLANK_LEADING && (idx != '0) && !upper_nz[idx];
        seg_next = (blank ? SEG_BLANK : dec_seg) ^ SEG_OFF;
        an_next  = (blank ? '0 : (DIGITS'(1) << idx)) ^ AN_OFF;
    end

    // Output registers: one cycle behind the counters, all-off while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_next;
            an          <= an_next;
            frame_start <= frame_first;
        end
    end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan (3 digits, 3 clocks per digit, active-low seg and an).
// Directed scenario tasks plus a randomized run checked every cycle against a frame-level model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bcd_seg7_scan;

    localparam int D     = 3;
    localparam int CPD   = 3;
    localparam int FRAME = D * CPD;

    localparam logic [6:0] LO_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] LO_DASH = 7'b0111111;
    localparam logic [6:0] LO_OFF  = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        updated = 1'b0;
    logic [11:0] bcd = 12'h000;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] cap_seg [3];
    logic [2:0] cap_an  [3];

    bcd_seg7_scan #(
        .DIGITS           (D),
        .CLOCKS_PER_DIGIT (CPD),
        .SEG_ACTIVE_LOW   (1'b1),
        .AN_ACTIVE_LOW    (1'b1),
        .BLANK_LEADING    (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd         (bcd),
        .updated     (updated),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Value v is an integer holding BCD nibbles; digit d is blank when v / 16^d is zero (d > 0).
    function automatic logic [6:0] m_seg(input int v, input int d);
        int up;
        int nib;
        up  = v / (16 ** d);
        nib = up % 16;
        if (d > 0 && up == 0) return LO_OFF;
        if (nib > 9) return LO_DASH;
        return LO_DIGIT[nib];
    endfunction

    function automatic logic [2:0] m_an(input int v, input int d);
        logic [2:0] r;
        r = 3'b111;
        if (d > 0 && v / (16 ** d) == 0) return r;
        r[d] = 1'b0;
        return r;
    endfunction

    int         m_e = 0;        // position within the frame of the next edge
    int         m_shown = 0;
    int         m_pend = 0;
    bit         m_pend_vld = 1'b0;
    logic [6:0] exp_seg;
    logic [2:0] exp_an;
    logic       exp_fs;

    always @(posedge clk) begin
        if (rst) begin
            m_e        <= 0;
            m_shown    <= 0;
            m_pend_vld <= 1'b0;
            exp_seg    <= LO_OFF;
            exp_an     <= 3'b111;
            exp_fs     <= 1'b0;
        end else begin
            exp_seg <= m_seg(m_shown, (m_e / CPD) % D);
            exp_an  <= m_an(m_shown, (m_e / CPD) % D);
            exp_fs  <= (m_e == 0);
            if (m_e == FRAME - 1) begin
                if (updated) m_shown <= int'(bcd);
                else if (m_pend_vld) m_shown <= m_pend;
                m_pend_vld <= 1'b0;
            end else if (updated) begin
                m_pend     <= int'(bcd);
                m_pend_vld <= 1'b1;
            end
            m_e <= (m_e + 1) % FRAME;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [11:0] v);
        bcd     = v;
        updated = 1'b1;
        @(negedge clk);
        updated = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: no frame_start within %0d cycles, required one", 2 * FRAME);
        end
    endtask

    // Samples seg/an at the start of each digit slot of the next frame.
    task automatic capture_frame();
        bit ok;
        wait_frame(ok);
        for (int d = 0; d < D; d++) begin
            if (d > 0) repeat (CPD) @(negedge clk);
            cap_seg[d] = seg;
            cap_an[d]  = an;
        end
    endtask

    function automatic logic [11:0] rand_bcd();
        int v;
        case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 4095);
            1: v = $urandom_range(0, 9);
            2: v = $urandom_range(0, 9) * 16 + $urandom_range(0, 9);
            default: v = $urandom_range(0, 9) * 256 + $urandom_range(0, 9) * 16 + $urandom_range(0, 9);
        endcase
        return 12'(v);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [2:0] e_an;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp += 3;
        if (seg !== LO_OFF) begin n_bad++; $display("FAIL reset_seg: got %b expected %b", seg, LO_OFF); end
        if (an !== 3'b111) begin n_bad++; $display("FAIL reset_an: got %b expected 111", an); end
        if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        rst = 1'b0;
        // Value 0 after reset: only digit 0 is enabled, its slot recurs every frame.
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            e_an = ((c % FRAME) < CPD) ? 3'b110 : 3'b111;
            n_cmp += 2;
            if (frame_start !== ((c % FRAME) == 0)) begin
                n_bad++; $display("FAIL reset_cadence_fs c=%0d: got %b expected %b", c, frame_start, (c % FRAME) == 0);
            end
            if (an !== e_an) begin n_bad++; $display("FAIL reset_cadence_an c=%0d: got %b expected %b", c, an, e_an); end
        end
    endtask

    task automatic test_scan();
        bit ok;
        logic [2:0] e_an;
        pulse(12'h888);
        wait_frame(ok);
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            e_an = (c < CPD) ? 3'b110 : (c < 2 * CPD) ? 3'b101 : 3'b011;
            n_cmp += 2;
            if (an !== e_an) begin n_bad++; $display("FAIL scan_an c=%0d: got %b expected %b", c, an, e_an); end
            if (seg !== 7'b0000000) begin n_bad++; $display("FAIL scan_seg c=%0d: got %b expected 0000000", c, seg); end
        end
    endtask

    task automatic test_display();
        pulse(12'h012);
        capture_frame();
        n_cmp += 6;
        if (cap_seg[0] !== 7'b0100100) begin n_bad++; $display("FAIL disp_seg0: got %b expected 0100100", cap_seg[0]); end
        if (cap_an[0] !== 3'b110) begin n_bad++; $display("FAIL disp_an0: got %b expected 110", cap_an[0]); end
        if (cap_seg[1] !== 7'b1111001) begin n_bad++; $display("FAIL disp_seg1: got %b expected 1111001", cap_seg[1]); end
        if (cap_an[1] !== 3'b101) begin n_bad++; $display("FAIL disp_an1: got %b expected 101", cap_an[1]); end
        if (cap_seg[2] !== LO_OFF) begin n_bad++; $display("FAIL disp_seg2: got %b expected 1111111", cap_seg[2]); end
        if (cap_an[2] !== 3'b111) begin n_bad++; $display("FAIL disp_an2: got %b expected 111", cap_an[2]); end
    endtask

    task automatic test_no_tearing();
        bit ok;
        wait_frame(ok);
        repeat (CPD) @(negedge clk);
        pulse(12'h345);
        n_cmp += 4;
        if (seg !== 7'b1111001) begin n_bad++; $display("FAIL tear_seg1: got %b expected 1111001", seg); end
        if (an !== 3'b101) begin n_bad++; $display("FAIL tear_an1: got %b expected 101", an); end
        repeat (2) @(negedge clk);
        if (seg !== LO_OFF) begin n_bad++; $display("FAIL tear_seg2: got %b expected 1111111", seg); end
        if (an !== 3'b111) begin n_bad++; $display("FAIL tear_an2: got %b expected 111", an); end
        capture_frame();
        n_cmp += 4;
        if (cap_seg[0] !== 7'b0010010) begin n_bad++; $display("FAIL tear_new0: got %b expected 0010010", cap_seg[0]); end
        if (cap_seg[1] !== 7'b0011001) begin n_bad++; $display("FAIL tear_new1: got %b expected 0011001", cap_seg[1]); end
        if (cap_seg[2] !== 7'b0110000) begin n_bad++; $display("FAIL tear_new2: got %b expected 0110000", cap_seg[2]); end
        if (cap_an[2] !== 3'b011) begin n_bad++; $display("FAIL tear_new_an2: got %b expected 011", cap_an[2]); end
    endtask

    task automatic test_invalid();
        pulse(12'h0A7);
        capture_frame();
        n_cmp += 5;
        if (cap_seg[0] !== 7'b1111000) begin n_bad++; $display("FAIL inv_seg0: got %b expected 1111000", cap_seg[0]); end
        if (cap_seg[1] !== LO_DASH) begin n_bad++; $display("FAIL inv_seg1: got %b expected 0111111", cap_seg[1]); end
        if (cap_an[1] !== 3'b101) begin n_bad++; $display("FAIL inv_an1: got %b expected 101", cap_an[1]); end
        if (cap_seg[2] !== LO_OFF) begin n_bad++; $display("FAIL inv_seg2: got %b expected 1111111", cap_seg[2]); end
        if (cap_an[2] !== 3'b111) begin n_bad++; $display("FAIL inv_an2: got %b expected 111", cap_an[2]); end
    endtask

    task automatic test_zero();
        pulse(12'h000);
        capture_frame();
        n_cmp += 4;
        if (cap_seg[0] !== 7'b1000000) begin n_bad++; $display("FAIL zero_seg0: got %b expected 1000000", cap_seg[0]); end
        if (cap_an[0] !== 3'b110) begin n_bad++; $display("FAIL zero_an0: got %b expected 110", cap_an[0]); end
        if (cap_an[1] !== 3'b111) begin n_bad++; $display("FAIL zero_an1: got %b expected 111", cap_an[1]); end
        if (cap_an[2] !== 3'b111) begin n_bad++; $display("FAIL zero_an2: got %b expected 111", cap_an[2]); end
    endtask

    task automatic test_boundary();
        bit ok;
        wait_frame(ok);
        pulse(12'h111);                 // pending, captured mid-frame
        repeat (FRAME - 3) @(negedge clk);
        pulse(12'h222);                 // strobe lands on the wrap edge
        @(negedge clk);
        n_cmp += 4;
        if (frame_start !== 1'b1) begin n_bad++; $display("FAIL bnd_fs: got %b expected 1", frame_start); end
        if (seg !== 7'b0100100) begin n_bad++; $display("FAIL bnd_seg0: got %b expected 0100100", seg); end
        if (an !== 3'b110) begin n_bad++; $display("FAIL bnd_an0: got %b expected 110", an); end
        repeat (CPD) @(negedge clk);
        if (seg !== 7'b0100100) begin n_bad++; $display("FAIL bnd_seg1: got %b expected 0100100", seg); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_frame(ok);
        pulse(12'h999);
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 3;
        if (seg !== LO_OFF) begin n_bad++; $display("FAIL rmid_seg: got %b expected 1111111", seg); end
        if (an !== 3'b111) begin n_bad++; $display("FAIL rmid_an: got %b expected 111", an); end
        if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rmid_fs: got %b expected 0", frame_start); end
        rst = 1'b0;
        capture_frame();
        n_cmp += 3;
        if (cap_seg[0] !== 7'b1000000) begin n_bad++; $display("FAIL rmid_seg0: got %b expected 1000000", cap_seg[0]); end
        if (cap_an[1] !== 3'b111) begin n_bad++; $display("FAIL rmid_an1: got %b expected 111", cap_an[1]); end
        if (cap_an[2] !== 3'b111) begin n_bad++; $display("FAIL rmid_an2: got %b expected 111", cap_an[2]); end
    endtask

    task automatic test_random();
        int shown_fails;
        shown_fails = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            n_cmp += 3;
            if (seg !== exp_seg) begin
                n_bad++;
                if (shown_fails++ < 20) $display("FAIL rand_seg c=%0d: got %b expected %b", c, seg, exp_seg);
            end
            if (an !== exp_an) begin
                n_bad++;
                if (shown_fails++ < 20) $display("FAIL rand_an c=%0d: got %b expected %b", c, an, exp_an);
            end
            if (frame_start !== exp_fs) begin
                n_bad++;
                if (shown_fails++ < 20) $display("FAIL rand_fs c=%0d: got %b expected %b", c, frame_start, exp_fs);
            end
            rst     = ($urandom_range(0, 149) == 0);
            updated = ($urandom_range(0, 4) == 0);
            bcd     = rand_bcd();
        end
        rst     = 1'b0;
        updated = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_display();
        test_no_tearing();
        test_invalid();
        test_zero();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
